cv32e40p_alu_ft_reconfig_ctrl: RTL and testbench
================================================

# cv32e40p_alu_ft_reconfig_ctrl

Reconfiguration controller for the fault-tolerant EX-stage ALU cluster (four replicas, three voted, one cold spare). It consumes the per-replica error-detected strobes from the voter mapping logic and counts them per replica, with leaky decay. It declares a replica permanently faulty at a threshold and swaps in the spare through a stall-protected warm-up sequence. It drives the voter mux selects, the replica clock-gate enables and the sticky fault status back into the ALU cluster and the performance counters.

## Interface
- ERR_THRESHOLD, 8: error count at which a replica is declared permanently faulty (≥2, ≤2^CNT_WIDTH-1)
- CNT_WIDTH, 4: width of each per-replica saturating error counter
- DECAY_PERIOD, 256: number of valid ALU ops between decay steps (power of two)
- WARMUP_CYCLES, 2: cycles the spare is clocked under stall before its output is voted (≥1)
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- alu_valid_i  in  1  an ALU op completes this cycle (operation issued, ex_ready_i high)
- alu_ready_i  in  1  voted ALU ready; low while a multicycle op (div/rem) is in flight
- ex_ready_i  in  1  EX stage ready
- err_detected_alu_i  in  4  per-physical-replica error strobe, already mapped so that unused replicas read 0
- sel_mux_ex_o  out  3  voter mux select; bit k=1 votes replica k, 0 votes replica 3
- clock_en_o  out  4  clock-gate enable per replica input pipe register
- used_alu_o  out  4  one-hot-of-three map of the voted replicas
- permanent_faulty_alu_o  out  4  sticky faulty flag per replica
- perf_faulty_pulse_o  out  4  one-cycle pulse when replica k becomes faulty
- err_count_o  out  4×CNT_WIDTH  current counter values, for debug and CSR readout
- reconfig_stall_o  out  1  stall request to the EX stage during warm-up
- degraded_o  out  1  sticky; fewer than three healthy voted replicas remain

## Operation
- Counters: on alu_valid_i, a replica with an asserted err_detected_alu_i bit has its counter incremented, saturating at 2^CNT_WIDTH-1. Counters of faulty replicas are frozen.
- Decay: a free-running op counter of log2(DECAY_PERIOD) bits increments on alu_valid_i. On the op where it wraps, every non-faulty counter >0 decrements by 1. If an increment and a decay fall on the same counter in the same op, the counter holds.
- Fault declaration: if the next counter value is ≥ERR_THRESHOLD, permanent_faulty_alu_o[k] is set on the same edge and perf_faulty_pulse_o[k] is high for the following cycle. The faulty flag clears only on rst.
- FSM states TMR, WARMUP, SPARE and DEGRADED:
  - TMR: sel=111, clock_en=0111, used=0111. Exactly one new faulty replica k∈{0,1,2} goes to WARMUP and latches k. Two or more new faulty replicas in one cycle go to DEGRADED.
  - WARMUP: clock_en=0111|1000 and reconfig_stall_o=1. The warm-up counter runs only while alu_ready_i=1, so an in-flight multicycle op completes first. After WARMUP_CYCLES counted cycles the FSM goes to SPARE. A new fault on another voted replica during WARMUP goes to DEGRADED, and the stall drops.
  - SPARE: sel[k]=0, clock_en=1111 with bit k cleared, used = 1111 with bit k cleared, stall=0. Any new faulty replica, including the spare, goes to DEGRADED.
  - DEGRADED: sel, clock_en and used hold their last values. degraded_o=1. It is left only by rst.
- A faulty flag on replica 3 while it is in standby cannot occur, because its input is masked to 0.

## Timing
- Reset values: sel=111, clock_en=0111, used=0111, all faulty/perf/count=0, stall=0, degraded=0, op counter 0, state TMR.
- All outputs are registered and there is no combinational input-to-output path.
- Latency:
  - error strobe to counter update: 1 edge
  - threshold-crossing strobe to faulty flag: 1 edge
  - perf pulse: the following cycle
  - faulty flag to WARMUP (stall high): 1 more edge
- sel_mux_ex_o switches on the same edge that reconfig_stall_o falls. No voted result is consumed with a mixed selection.
- If ex_ready_i=0 throughout WARMUP, the stall stays asserted. The swap completes only after WARMUP_CYCLES cycles with alu_ready_i=1.
- A rst assertion mid-WARMUP returns the block to its reset values on the next edge. Fault history is lost.

## Test plan
- Reset, then 100 valid ops with no errors → sel=111, clock_en=0111, all counts 0, stall never high.
- 8 valid ops with err bit 1 set → count[1] 1..8. faulty[1] is set at the 8th edge. The perf pulse on bit 1 is high the next cycle. Stall is high for 2 cycles, then sel=101, clock_en=1101, used=1101.
- 7 errors on replica 0, then 256 clean valid ops → count[0]=6 and no fault. Error on the decay-wrap op → count holds.
- Fault replica 2 while alu_ready_i=0 for 10 cycles → stall stays high, sel stays 111. The swap completes 2 cycles after ready rises.
- In SPARE (replica 1 replaced), 8 errors on replica 3 → faulty=1010, degraded_o=1, sel stays 101.
- Same-cycle threshold crossing on replicas 0 and 2 → DEGRADED directly, no stall, sel=111. Then rst → all reset values.

Source files
------------

// File: rtl/cv32e40p_alu_ft_reconfig_ctrl.sv
// rtl/cv32e40p_alu_ft_reconfig_ctrl.sv - leaky per-replica error counting and TMR-to-spare reconfiguration FSM
module cv32e40p_alu_ft_reconfig_ctrl #(
    parameter int ERR_THRESHOLD = 8,
    parameter int CNT_WIDTH     = 4,
    parameter int DECAY_PERIOD  = 256,
    parameter int WARMUP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid_i,
    input  logic                   alu_ready_i,
    input  logic                   ex_ready_i,
    input  logic [3:0]             err_detected_alu_i,
    output logic [2:0]             sel_mux_ex_o,
    output logic [3:0]             clock_en_o,
    output logic [3:0]             used_alu_o,
    output logic [3:0]             permanent_faulty_alu_o,
    output logic [3:0]             perf_faulty_pulse_o,
    output logic [4*CNT_WIDTH-1:0] err_count_o,
    output logic                   reconfig_stall_o,
    output logic                   degraded_o
);
    localparam int OP_W = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;
    localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(ERR_THRESHOLD);
    localparam logic [WU_W-1:0]      WU_LAST = WU_W'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {S_TMR, S_WARMUP, S_SPARE, S_DEGRADED} state_t;

    state_t                state_q, state_d;
    logic [OP_W-1:0]       op_cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_q [4];
    logic [CNT_WIDTH-1:0]  cnt_d [4];
    logic [3:0]            inc, dec, fault_set, spare_mask, new_voted;
    logic                  wrap;
    logic [1:0]            idx_q, idx_d;
    logic [WU_W-1:0]       wu_q, wu_d;
    logic [2:0]            sel_d;
    logic [3:0]            en_d, used_d;
    logic                  stall_d, degraded_d;

    // EX readiness is implied by the stall itself; only alu_ready_i gates warm-up progress.
    logic unused_ex_ready;
    assign unused_ex_ready = ex_ready_i;

    assign wrap = alu_valid_i && (op_cnt_q == '1);

    always_comb begin
        inc       = '0;
        dec       = '0;
        fault_set = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            inc[k]   = alu_valid_i && err_detected_alu_i[k] && !permanent_faulty_alu_o[k];
            dec[k]   = wrap && !permanent_faulty_alu_o[k] && (cnt_q[k] != '0);
            if (inc[k] && !dec[k] && cnt_q[k] != CNT_MAX)
                cnt_d[k] = cnt_q[k] + 1'b1;
            else if (dec[k] && !inc[k])
                cnt_d[k] = cnt_q[k] - 1'b1;
            fault_set[k] = !permanent_faulty_alu_o[k] && (cnt_d[k] >= THRESH);
        end
    end

    always_comb begin
        err_count_o = '0;
        for (int k = 0; k < 4; k++)
            err_count_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end

    assign spare_mask = 4'b0001 << idx_q;
    assign new_voted  = perf_faulty_pulse_o & 4'b0111;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wu_d       = wu_q;
        sel_d      = sel_mux_ex_o;
        en_d       = clock_en_o;
        used_d     = used_alu_o;
        stall_d    = 1'b0;
        degraded_d = degraded_o;
        case (state_q)
            S_TMR: begin
                case (new_voted)
                    4'b0000: ;
                    4'b0001: begin state_d = S_WARMUP; idx_d = 2'd0; end
                    4'b0010: begin state_d = S_WARMUP; idx_d = 2'd1; end
                    4'b0100: begin state_d = S_WARMUP; idx_d = 2'd2; end
                    default: state_d = S_DEGRADED;
                endcase
                if (state_d == S_WARMUP) begin
                    wu_d    = '0;
                    en_d    = 4'b1111;
                    stall_d = 1'b1;
                end
            end
            S_WARMUP: begin
                stall_d = 1'b1;
                if ((new_voted & ~spare_mask) != 4'b0000) begin
                    state_d = S_DEGRADED;
                    stall_d = 1'b0;
                end else if (alu_ready_i) begin
                    if (wu_q == WU_LAST) begin
                        // Selection and stall change on the same edge, so no mixed vote is consumed.
                        state_d = S_SPARE;
                        stall_d = 1'b0;
                        sel_d   = 3'b111 & ~spare_mask[2:0];
                        en_d    = 4'b1111 & ~spare_mask;
                        used_d  = 4'b1111 & ~spare_mask;
                    end else begin
                        wu_d = wu_q + 1'b1;
                    end
                end
            end
            S_SPARE: begin
                if (perf_faulty_pulse_o != 4'b0000)
                    state_d = S_DEGRADED;
            end
            default: ;
        endcase
        if (state_d == S_DEGRADED)
            degraded_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= S_TMR;
            op_cnt_q               <= '0;
            idx_q                  <= '0;
            wu_q                   <= '0;
            sel_mux_ex_o           <= 3'b111;
            clock_en_o             <= 4'b0111;
            used_alu_o             <= 4'b0111;
            permanent_faulty_alu_o <= '0;
            perf_faulty_pulse_o    <= '0;
            reconfig_stall_o       <= 1'b0;
            degraded_o             <= 1'b0;
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            state_q                <= state_d;
            if (alu_valid_i) op_cnt_q <= op_cnt_q + 1'b1;
            idx_q                  <= idx_d;
            wu_q                   <= wu_d;
            sel_mux_ex_o           <= sel_d;
            clock_en_o             <= en_d;
            used_alu_o             <= used_d;
            permanent_faulty_alu_o <= permanent_faulty_alu_o | fault_set;
            perf_faulty_pulse_o    <= fault_set;
            reconfig_stall_o       <= stall_d;
            degraded_o             <= degraded_d;
            for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
        end
    end
endmodule

// File: tb/tb_cv32e40p_alu_ft_reconfig_ctrl.sv
// tb/tb_cv32e40p_alu_ft_reconfig_ctrl.sv - directed bench for the ALU reconfiguration controller
module tb_cv32e40p_alu_ft_reconfig_ctrl;
    logic        clk = 1'b0;
    logic        rst, alu_valid, alu_ready, ex_ready;
    logic [3:0]  err;
    logic [2:0]  sel;
    logic [3:0]  clock_en, used, faulty, perf;
    logic [15:0] err_count;
    logic        stall, degraded;
    int          checks = 0;
    int          errors = 0;

    cv32e40p_alu_ft_reconfig_ctrl dut (
        .clk(clk), .rst(rst), .alu_valid_i(alu_valid), .alu_ready_i(alu_ready),
        .ex_ready_i(ex_ready), .err_detected_alu_i(err), .sel_mux_ex_o(sel),
        .clock_en_o(clock_en), .used_alu_o(used), .permanent_faulty_alu_o(faulty),
        .perf_faulty_pulse_o(perf), .err_count_o(err_count),
        .reconfig_stall_o(stall), .degraded_o(degraded)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] cnt(input int k);
        return err_count[k*4 +: 4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] e);
        alu_valid = 1'b1;
        err       = e;
        step();
        alu_valid = 1'b0;
        err       = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; alu_valid = 1'b0; alu_ready = 1'b1; ex_ready = 1'b1; err = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sel !== 3'b111) begin errors++; $display("FAIL reset_sel got %b exp 111", sel); end
        checks++; if (clock_en !== 4'b0111) begin errors++; $display("FAIL reset_clock_en got %b exp 0111", clock_en); end
        checks++; if (used !== 4'b0111) begin errors++; $display("FAIL reset_used got %b exp 0111", used); end
        checks++; if ({faulty, perf} !== 8'h00) begin errors++; $display("FAIL reset_faulty_perf got %b exp 0", {faulty, perf}); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL reset_counts got %h exp 0000", err_count); end
        checks++; if ({stall, degraded} !== 2'b00) begin errors++; $display("FAIL reset_stall_degraded got %b exp 00", {stall, degraded}); end
    endtask

    task automatic test_clean_ops();
        logic stall_seen = 1'b0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            op(4'b0000);
            stall_seen |= stall;
        end
        checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL clean_stall got 1 exp 0"); end
        checks++; if ({sel, clock_en} !== 7'b111_0111) begin errors++; $display("FAIL clean_sel_en got %b exp 1110111", {sel, clock_en}); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL clean_counts got %h exp 0000", err_count); end
    endtask

    task automatic test_fault_swap();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            op(4'b0010);
            checks++; if (cnt(1) !== 4'(i)) begin errors++; $display("FAIL swap_count1 op %0d got %0d exp %0d", i, cnt(1), i); end
            checks++; if (faulty !== ((i == 8) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL swap_faulty op %0d got %b", i, faulty); end
        end
        checks++; if ({perf, stall} !== 5'b0010_0) begin errors++; $display("FAIL swap_perf got %b exp 00100", {perf, stall}); end
        step();
        checks++; if ({stall, perf, sel, clock_en} !== 12'b1_0000_111_1111) begin errors++; $display("FAIL swap_warm1 got %b exp 100001111111", {stall, perf, sel, clock_en}); end
        step();
        checks++; if ({stall, sel} !== 4'b1_111) begin errors++; $display("FAIL swap_warm2 got %b exp 1111", {stall, sel}); end
        step();
        checks++; if ({stall, sel, clock_en, used} !== 12'b0_101_1101_1101) begin errors++; $display("FAIL swap_spare got %b exp 010111011101", {stall, sel, clock_en, used}); end
    endtask

    task automatic test_decay();
        do_reset();
        repeat (7) op(4'b0001);
        checks++; if (cnt(0) !== 4'd7) begin errors++; $display("FAIL decay_pre got %0d exp 7", cnt(0)); end
        repeat (256) op(4'b0000);
        checks++; if ({cnt(0), faulty} !== 8'h60) begin errors++; $display("FAIL decay_once got %h exp 60", {cnt(0), faulty}); end
        repeat (248) op(4'b0000);
        op(4'b0001);
        checks++; if (cnt(0) !== 4'd6) begin errors++; $display("FAIL decay_collide got %0d exp 6", cnt(0)); end
        op(4'b0001);
        checks++; if (cnt(0) !== 4'd7) begin errors++; $display("FAIL decay_inc_after got %0d exp 7", cnt(0)); end
    endtask

    task automatic test_stall_ready();
        do_reset();
        repeat (8) op(4'b0100);
        alu_ready = 1'b0;
        ex_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if ({stall, sel} !== 4'b1_111) begin errors++; $display("FAIL hold_stall cyc %0d got %b exp 1111", i, {stall, sel}); end
        end
        alu_ready = 1'b1;
        step();
        checks++; if ({stall, sel} !== 4'b1_111) begin errors++; $display("FAIL hold_ready1 got %b exp 1111", {stall, sel}); end
        step();
        checks++; if ({stall, sel, clock_en, used} !== 12'b0_011_1011_1011) begin errors++; $display("FAIL hold_spare got %b exp 001110111011", {stall, sel, clock_en, used}); end
        ex_ready = 1'b1;
    endtask

    task automatic test_spare_fault();
        do_reset();
        repeat (8) op(4'b0010);
        repeat (3) step();
        repeat (8) op(4'b1000);
        checks++; if ({faulty, perf} !== 8'b1010_1000) begin errors++; $display("FAIL spare_faulty got %b exp 10101000", {faulty, perf}); end
        step();
        checks++; if ({degraded, stall, sel, clock_en} !== 9'b1_0_101_1101) begin errors++; $display("FAIL spare_degraded got %b exp 101011101", {degraded, stall, sel, clock_en}); end
        checks++; if (cnt(3) !== 4'd8) begin errors++; $display("FAIL spare_count3 got %0d exp 8", cnt(3)); end
    endtask

    task automatic test_double_fault();
        do_reset();
        repeat (8) op(4'b0101);
        checks++; if ({faulty, perf} !== 8'b0101_0101) begin errors++; $display("FAIL double_faulty got %b exp 01010101", {faulty, perf}); end
        step();
        checks++; if ({degraded, stall, sel, clock_en} !== 9'b1_0_111_0111) begin errors++; $display("FAIL double_degraded got %b exp 101110111", {degraded, stall, sel, clock_en}); end
        step();
        checks++; if ({degraded, stall} !== 2'b10) begin errors++; $display("FAIL double_sticky got %b exp 10", {degraded, stall}); end
        do_reset();
        checks++; if ({degraded, stall, sel, clock_en, used, faulty, perf} !== 21'b0_0_111_0111_0111_0000_0000) begin errors++; $display("FAIL double_rst got %b", {degraded, stall, sel, clock_en, used, faulty, perf}); end
        checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL double_rst_counts got %h exp 0000", err_count); end
    endtask

    task automatic test_reset_mid_warmup();
        do_reset();
        repeat (8) op(4'b0001);
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midwarm_enter got %b exp 1", stall); end
        do_reset();
        checks++; if ({stall, sel, clock_en, faulty} !== 12'b0_111_0111_0000) begin errors++; $display("FAIL midwarm_rst got %b exp 011101110000", {stall, sel, clock_en, faulty}); end
        checks++; if (cnt(0) !== 4'd0) begin errors++; $display("FAIL midwarm_count got %0d exp 0", cnt(0)); end
    endtask

    initial begin
        test_reset();
        test_clean_ops();
        test_fault_swap();
        test_decay();
        test_stall_ready();
        test_spare_fault();
        test_double_fault();
        test_reset_mid_warmup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
